stack_word_ctrl: RTL and testbench

STACK_WORD_CTRL -- requirements
Module: stack_word_ctrl

---
 rtl/stack_pkg.sv | 35 +++
 rtl/stack_guard.sv | 34 +++
 rtl/stack_word_ctrl.sv | 166 ++++++++++++++++
 tb/tb_stack_word_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// -----------------------------------------------------------------------------
// stack_pkg
// Shared definitions for the word-over-byte stack controller:
//   - FSM state encoding (plain localparams so older tools can read them)
//   - operation direction constants (OP_PUSH / OP_POP)
//   - byte-order constants: the high byte is pushed first, so the low byte
//     sits on top and is the first byte popped back.
//   - word_byte(): selects one byte of a 16-bit word by byte index.
// -----------------------------------------------------------------------------
package stack_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_PUSH_HI = 3'd1;
    localparam logic [2:0] ST_PUSH_LO = 3'd2;
    localparam logic [2:0] ST_POP_LO  = 3'd3;
    localparam logic [2:0] ST_POP_HI  = 3'd4;
    localparam logic [2:0] ST_POP_CAP = 3'd5;
    localparam logic [2:0] ST_DONE    = 3'd6;

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    localparam logic BYTE_LO = 1'b0;
    localparam logic BYTE_HI = 1'b1;

    // Push order puts the high byte deeper in the stack; pop therefore
    // returns the low byte first.
    localparam logic PUSH_FIRST_BYTE = BYTE_HI;
    localparam logic POP_FIRST_BYTE  = BYTE_LO;

    function automatic logic [7:0] word_byte(input logic [15:0] w, input logic sel);
        return (sel == BYTE_HI) ? w[15:8] : w[7:0];
    endfunction

endpackage

// File: rtl/stack_guard.sv
// -----------------------------------------------------------------------------
// stack_guard
// Combinational stack-pointer bounds check for one word (two bytes).
//   sp_i  : current byte stack pointer
//   pop_i : requested direction (OP_POP / OP_PUSH)
//   ok_o  : 1 when the word operation fits inside [SP_LIMIT_LO, SP_LIMIT_HI]
// A push needs sp >= SP_LIMIT_LO + 2, a pop needs sp <= SP_LIMIT_HI - 2.
// Both compares are done in 17 bits so limits near 0 or 16'hFFFF never wrap.
// -----------------------------------------------------------------------------
module stack_guard
    import stack_pkg::*;
#(
    parameter logic [15:0] SP_LIMIT_LO = 16'h0000,
    parameter logic [15:0] SP_LIMIT_HI = 16'hFFFF
) (
    input  logic [15:0] sp_i,
    input  logic        pop_i,
    output logic        ok_o
);

    logic [16:0] sp_ext;

    assign sp_ext = {1'b0, sp_i};

    always_comb begin
        if (pop_i == OP_POP) begin
            // sp + 2 <= HI is the wrap-free form of sp <= HI - 2
            ok_o = (sp_ext + 17'd2) <= {1'b0, SP_LIMIT_HI};
        end else begin
            ok_o = sp_ext >= ({1'b0, SP_LIMIT_LO} + 17'd2);
        end
    end

endmodule

// File: rtl/stack_word_ctrl.sv
// -----------------------------------------------------------------------------
// stack_word_ctrl
// Moves 16-bit words onto / off a byte-wide stack, two byte strobes per word.
//
// Optional feature macro: STACK_GUARD_EN
//   defined   : stk_sp is checked on accept; an out-of-range request goes
//               straight to DONE with no strobes and op_err set with op_ack.
//   undefined : no check, op_err is tied 0, SP_LIMIT_LO/HI are unused.
//
// Ports
//   clk, reset                      clock (rising edge), async active-high reset
//   op_req, op_pop, op_wdata        word request; sampled/latched in IDLE only
//   op_ack, op_err, op_rdata        completion pulse, guard error, popped word
//   busy                            high in every non-IDLE state
//   stk_enable/decrement/increment  byte strobes (decrement = push, increment = pop)
//   stk_wdata                       byte to push (holds outside push states)
//   stk_rdata, stk_sp               registered pop byte, current byte pointer
//   dbg_state                       current FSM state (stack_pkg encoding)
//
// Handshake: a request is taken on the rising edge where state is IDLE and
// op_req is 1; op_ack is a single-cycle pulse in DONE, and DONE always returns
// to IDLE, so op_req held high is re-accepted the cycle after DONE.
// -----------------------------------------------------------------------------
module stack_word_ctrl
    import stack_pkg::*;
#(
    parameter logic [15:0] SP_LIMIT_LO = 16'h0000,
    parameter logic [15:0] SP_LIMIT_HI = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_req,
    input  logic        op_pop,
    input  logic [15:0] op_wdata,
    output logic        op_ack,
    output logic [15:0] op_rdata,
    output logic        op_err,
    output logic        busy,
    output logic        stk_enable,
    output logic        stk_decrement,
    output logic        stk_increment,
    output logic [7:0]  stk_wdata,
    input  logic [7:0]  stk_rdata,
    input  logic [15:0] stk_sp,
    output logic [2:0]  dbg_state
);

    logic [2:0]  state_q, state_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  stk_wdata_q, stk_wdata_d;
    logic [7:0]  first_q, first_d;
    logic [15:0] op_rdata_q, op_rdata_d;
    logic        guard_fail;

`ifdef STACK_GUARD_EN
    logic guard_ok;
    logic err_q, err_d;

    stack_guard #(
        .SP_LIMIT_LO (SP_LIMIT_LO),
        .SP_LIMIT_HI (SP_LIMIT_HI)
    ) u_guard (
        .sp_i  (stk_sp),
        .pop_i (op_pop),
        .ok_o  (guard_ok)
    );

    assign guard_fail = ~guard_ok;
    assign op_err     = err_q & (state_q == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        err_d = err_q;
        if (state_q == ST_IDLE && op_req) begin
            err_d = guard_fail;
        end
    end
`else
    localparam logic [15:0] UNUSED_LIMITS = SP_LIMIT_LO ^ SP_LIMIT_HI;
    logic unused_sp;

    assign unused_sp  = ^{stk_sp, UNUSED_LIMITS};
    assign guard_fail = 1'b0;
    assign op_err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wdata_d     = wdata_q;
        stk_wdata_d = stk_wdata_q;
        first_d     = first_q;
        op_rdata_d  = op_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (op_req) begin
                    wdata_d = op_wdata;
                    if (guard_fail) begin
                        state_d = ST_DONE;
                    end else if (op_pop == OP_POP) begin
                        state_d = ST_POP_LO;
                    end else begin
                        state_d     = ST_PUSH_HI;
                        // Loaded at accept so the byte is on the bus during PUSH_HI.
                        stk_wdata_d = word_byte(op_wdata, PUSH_FIRST_BYTE);
                    end
                end
            end
            ST_PUSH_HI: begin
                state_d     = ST_PUSH_LO;
                stk_wdata_d = word_byte(wdata_q, ~PUSH_FIRST_BYTE);
            end
            ST_PUSH_LO: state_d = ST_DONE;
            ST_POP_LO:  state_d = ST_POP_HI;
            ST_POP_HI: begin
                // First popped byte is staged here so op_rdata only changes
                // once the whole word is in hand.
                state_d = ST_POP_CAP;
                first_d = stk_rdata;
            end
            ST_POP_CAP: begin
                state_d = ST_DONE;
                if (POP_FIRST_BYTE == BYTE_LO) begin
                    op_rdata_d = {stk_rdata, first_q};
                end else begin
                    op_rdata_d = {first_q, stk_rdata};
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wdata_q     <= 16'h0000;
            stk_wdata_q <= 8'h00;
            first_q     <= 8'h00;
            op_rdata_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            wdata_q     <= wdata_d;
            stk_wdata_q <= stk_wdata_d;
            first_q     <= first_d;
            op_rdata_q  <= op_rdata_d;
        end
    end

    // Strobes decode straight from state so reset removes them immediately.
    assign stk_decrement = (state_q == ST_PUSH_HI) || (state_q == ST_PUSH_LO);
    assign stk_increment = (state_q == ST_POP_LO)  || (state_q == ST_POP_HI);
    assign stk_enable    = stk_decrement | stk_increment;
    assign stk_wdata     = stk_wdata_q;
    assign op_ack        = (state_q == ST_DONE);
    assign busy          = (state_q != ST_IDLE);
    assign op_rdata      = op_rdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_stack_word_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stack_word_ctrl
// Directed bench for stack_word_ctrl with a reactive byte-stack model.
// Drivers push {err, rdata}, ack cycle and strobe count into expected queues
// when a request is issued; a negedge monitor pops and compares on op_ack.
// Guard cases are compiled only when STACK_GUARD_EN is defined.
// -----------------------------------------------------------------------------
module tb_stack_word_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_req;
  logic        op_pop;
  logic [15:0] op_wdata;
  logic        op_ack;
  logic [15:0] op_rdata;
  logic        op_err;
  logic        busy;
  logic        stk_enable;
  logic        stk_decrement;
  logic        stk_increment;
  logic [7:0]  stk_wdata;
  logic [7:0]  stk_rdata = 8'h00;
  logic [15:0] stk_sp;
  logic [2:0]  dbg_state;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cyc      = 0;
  int strb_cnt = 0;

  logic [16:0] exp_q[$];
  int          exp_cyc_q[$];
  int          exp_strb_q[$];

  // byte stack model
  logic [7:0]  mem [0:65535];
  logic [15:0] model_sp = 16'h0100;
  logic [15:0] sp_m1;
  logic        sp_load = 1'b0;
  logic [15:0] sp_load_val = 16'h0000;

  // continuous-request table: push exp rdata is the last popped word
  logic        alt_pop [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] alt_w   [6] = '{16'h1234, 16'hFFFF, 16'hA55A, 16'hFFFF, 16'h00FF, 16'hFFFF};
  logic [15:0] alt_rd  [6] = '{16'h1111, 16'h1234, 16'h1234, 16'hA55A, 16'hA55A, 16'h00FF};

  stack_word_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .op_req        (op_req),
    .op_pop        (op_pop),
    .op_wdata      (op_wdata),
    .op_ack        (op_ack),
    .op_rdata      (op_rdata),
    .op_err        (op_err),
    .busy          (busy),
    .stk_enable    (stk_enable),
    .stk_decrement (stk_decrement),
    .stk_increment (stk_increment),
    .stk_wdata     (stk_wdata),
    .stk_rdata     (stk_rdata),
    .stk_sp        (stk_sp),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset-independent infrastructure ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign stk_sp = model_sp;
  assign sp_m1  = model_sp - 16'd1;

  always @(posedge clk) begin
    if (sp_load) begin
      model_sp <= sp_load_val;
    end else if (stk_enable && stk_decrement) begin
      mem[sp_m1] <= stk_wdata;
      model_sp   <= sp_m1;
    end else if (stk_enable && stk_increment) begin
      stk_rdata <= mem[model_sp];
      model_sp  <= model_sp + 16'd1;
    end
  end

  // ---------------- compare helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [16:0] e;
    int          ec;
    int          es;
    if (reset) begin
      strb_cnt = 0;
    end else begin
      if (stk_enable) begin
        strb_cnt++;
        chk("strobe_onehot", {31'b0, stk_decrement ^ stk_increment}, 32'd1);
      end
      if (op_ack) begin
        chk("ack_strobes_low", {29'b0, stk_enable, stk_decrement, stk_increment}, 32'd0);
        if (exp_q.size() == 0) begin
          vec_cnt++;
          miss_cnt++;
          $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
        end else begin
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          es = exp_strb_q.pop_front();
          chk("ack_rdata", {16'b0, op_rdata}, {16'b0, e[15:0]});
          chk("ack_err", {31'b0, op_err}, {31'b0, e[16]});
          chk("ack_cycle", cyc, ec);
          chk("strobes_per_word", strb_cnt, es);
        end
        strb_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      vec_cnt++;
      miss_cnt++;
      $display("FAIL idle_timeout: busy still %0b expected 0", busy);
    end
  endtask

  // Issues one request in the current (IDLE) cycle and returns in cycle 1.
  task automatic issue(input logic pop, input logic [15:0] w, input logic want_ack,
                       input logic [15:0] exp_rd, input logic exp_err, output int lat);
    lat = exp_err ? 1 : (pop ? 4 : 3);
    op_req   = 1'b1;
    op_pop   = pop;
    op_wdata = w;
    if (want_ack) begin
      exp_q.push_back({exp_err, exp_rd});
      exp_cyc_q.push_back(cyc + lat);
      exp_strb_q.push_back(exp_err ? 0 : 2);
    end
    @(negedge clk);
    op_req = 1'b0;
  endtask

  task automatic run_op(input logic pop, input logic [15:0] w,
                        input logic [15:0] exp_rd, input logic exp_err);
    int lat;
    wait_idle();
    issue(pop, w, 1'b1, exp_rd, exp_err, lat);
    repeat (lat) @(negedge clk);
  endtask

  task automatic load_sp(input logic [15:0] v);
    sp_load     = 1'b1;
    sp_load_val = v;
    @(negedge clk);
    sp_load = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int n;
    reset    = 1'b1;
    op_req   = 1'b0;
    op_pop   = 1'b0;
    op_wdata = 16'h0000;
    repeat (3) @(negedge clk);

    chk("rst_ack", {31'b0, op_ack}, 32'd0);
    chk("rst_err", {31'b0, op_err}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rdata", {16'b0, op_rdata}, 32'h0000);
    chk("rst_wdata", {24'b0, stk_wdata}, 32'h00);
    chk("rst_strobes", {29'b0, stk_enable, stk_decrement, stk_increment}, 32'd0);

    reset = 1'b0;
    @(negedge clk);

    // push 16'hBEEF at sp 16'h0100
    issue(1'b0, 16'hBEEF, 1'b1, 16'h0000, 1'b0, lat);
    chk("push_c1_strb", {29'b0, stk_enable, stk_decrement, stk_increment}, 32'b110);
    chk("push_c1_wdata", {24'b0, stk_wdata}, 32'hBE);
    chk("push_c1_busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    chk("push_c2_strb", {29'b0, stk_enable, stk_decrement, stk_increment}, 32'b110);
    chk("push_c2_wdata", {24'b0, stk_wdata}, 32'hEF);
    repeat (2) @(negedge clk);
    chk("push_wdata_hold", {24'b0, stk_wdata}, 32'hEF);
    chk("push_sp", {16'b0, model_sp}, 32'h00FE);

    // pop it back
    issue(1'b1, 16'h0000, 1'b1, 16'hBEEF, 1'b0, lat);
    chk("pop_c1_strb", {29'b0, stk_enable, stk_decrement, stk_increment}, 32'b101);
    @(negedge clk);
    chk("pop_c2_strb", {29'b0, stk_enable, stk_decrement, stk_increment}, 32'b101);
    @(negedge clk);
    chk("pop_c3_strb", {29'b0, stk_enable, stk_decrement, stk_increment}, 32'd0);
    chk("pop_c3_wdata_hold", {24'b0, stk_wdata}, 32'hEF);
    repeat (2) @(negedge clk);

    // reset in cycle 2 of a pop
    run_op(1'b0, 16'h5AA5, 16'hBEEF, 1'b0);
    wait_idle();
    issue(1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0, lat);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid_strobes", {29'b0, stk_enable, stk_decrement, stk_increment}, 32'd0);
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_ack", {31'b0, op_ack}, 32'd0);
    chk("rstmid_rdata", {16'b0, op_rdata}, 32'h0000);
    repeat (2) @(negedge clk);
    chk("rstmid_no_ack", {31'b0, op_ack}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_idle", {31'b0, busy}, 32'd0);

    // LIFO order, op_rdata untouched by pushes
    run_op(1'b0, 16'h1357, 16'h0000, 1'b0);
    run_op(1'b1, 16'h0000, 16'h1357, 1'b0);
    run_op(1'b0, 16'h1111, 16'h1357, 1'b0);
    run_op(1'b0, 16'h2222, 16'h1357, 1'b0);
    run_op(1'b1, 16'h0000, 16'h2222, 1'b0);
    run_op(1'b1, 16'h0000, 16'h1111, 1'b0);

    // op_req held high, alternating direction; inputs change while busy
    wait_idle();
    op_req   = 1'b1;
    op_pop   = alt_pop[0];
    op_wdata = alt_w[0];
    for (int i = 0; i < 6; i++) begin
      lat = alt_pop[i] ? 4 : 3;
      exp_q.push_back({1'b0, alt_rd[i]});
      exp_cyc_q.push_back(cyc + lat);
      exp_strb_q.push_back(2);
      @(negedge clk);
      chk("held_req_busy", {31'b0, busy}, 32'd1);
      if (i < 5) begin
        op_pop   = alt_pop[i + 1];
        op_wdata = alt_w[i + 1];
      end else begin
        op_req = 1'b0;
      end
      repeat (lat) @(negedge clk);
    end

`ifdef STACK_GUARD_EN
    wait_idle();
    load_sp(16'h0001);
    run_op(1'b0, 16'hCAFE, 16'h00FF, 1'b1);
    chk("guard_push_sp", {16'b0, model_sp}, 32'h0001);
    load_sp(16'h0002);
    run_op(1'b0, 16'h4321, 16'h00FF, 1'b0);
    load_sp(16'hFFFE);
    run_op(1'b1, 16'h0000, 16'h00FF, 1'b1);
    mem[16'hFFFD] = 8'h34;
    mem[16'hFFFE] = 8'h12;
    load_sp(16'hFFFD);
    run_op(1'b1, 16'h0000, 16'h1234, 1'b0);
`endif

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached with %0d entries pending", exp_q.size());
    $fatal(1, "watchdog");
  end

endmodule
